// File: rtl/qpsk_pkg.sv
// Shared QPSK definitions: phase-index mapping, frame-sync FSM states,
// default start-of-frame word.
package qpsk_pkg;

   typedef enum logic [1:0] {SEARCH, PAYLOAD, CHECK} fsm_t;

   localparam int          DEF_SOF_LEN     = 26;
   localparam logic [25:0] DEF_SOF_PATTERN = 26'h3278428;

   // symbol {I,Q} -> phase index: 00->0, 10->1, 11->2, 01->3
   function automatic logic [1:0] sym2idx(input logic [1:0] s);
      return {s[0], s[1] ^ s[0]};
   endfunction

   // phase index -> symbol {I,Q}
   function automatic logic [1:0] idx2sym(input logic [1:0] i);
      return {i[1] ^ i[0], i[1]};
   endfunction

   // rotate a symbol back by r quarter turns
   function automatic logic [1:0] derot(input logic [1:0] s, input logic [1:0] r);
      return idx2sym(sym2idx(s) - r);
   endfunction

endpackage

// File: rtl/sof_correlator.sv
// Combinational SOF correlator: scores the symbol window against the SOF
// word under all four phase rotations and reports the strongest one.
// window[0] is the newest symbol and lines up with pattern[0] (the last
// SOF bit sent).
module sof_correlator
   import qpsk_pkg::*;
#(
   parameter int SOF_LEN = 26,
   parameter int MAX_ERR = 3
)(
   input  logic [SOF_LEN-1:0][1:0]         window,
   input  logic [SOF_LEN-1:0]              pattern,
   output logic [1:0]                      best,
   output logic [$clog2(SOF_LEN+1)-1:0]    match_best,
   output logic                            hit
);
   localparam int            CW     = $clog2(SOF_LEN+1);
   localparam logic [CW-1:0] THRESH = CW'(SOF_LEN - MAX_ERR);

   logic [3:0][CW-1:0] match;

   // count agreeing window positions for each candidate rotation
   always_comb begin
      match = '0;
      for (int r = 0; r < 4; r++)
         for (int k = 0; k < SOF_LEN; k++)
            if (derot(window[k], 2'(r)) == {pattern[k], pattern[k]})
               match[r] = match[r] + CW'(1);
   end

   // strongest rotation; strict compare keeps the lowest index on ties
   always_comb begin
      best       = 2'd0;
      match_best = match[0];
      for (int r = 1; r < 4; r++)
         if (match[r] > match_best) begin
            best       = 2'(r);
            match_best = match[r];
         end
   end

   assign hit = (match_best >= THRESH);

endmodule

// File: rtl/qpsk_frame_sync.sv
// QPSK frame synchroniser: finds the SOF under any 90-degree ambiguity,
// derotates and frames the payload, and flywheels through bad SOFs.
module qpsk_frame_sync
   import qpsk_pkg::*;
#(
   parameter int                 SOF_LEN     = DEF_SOF_LEN,
   parameter logic [SOF_LEN-1:0] SOF_PATTERN = SOF_LEN'(DEF_SOF_PATTERN),
   parameter int                 FRAME_LEN   = 63,
   parameter int                 MAX_ERR     = 3,
   parameter int                 MISS_LIMIT  = 3
)(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       in_valid,
   input  logic [1:0] in_data,
   output logic       in_ready,
   output logic       out_valid,
   input  logic       out_ready,
   output logic [1:0] out_data,
   output logic       out_sof,
   output logic       out_eof,
   output logic       locked,
   output logic [1:0] rot,
   output logic       sof_miss
);
   localparam int CW = $clog2(SOF_LEN+1);
   localparam int PW = $clog2(FRAME_LEN);
   localparam int SW = $clog2(SOF_LEN);
   localparam int MW = $clog2(MISS_LIMIT+1);

   fsm_t                    state, state_nx;
   logic [SOF_LEN-2:0][1:0] hist;
   logic [SOF_LEN-1:0][1:0] window;
   logic [PW-1:0]           pay_cnt;
   logic [SW-1:0]           sof_cnt;
   logic [MW-1:0]           miss_cnt, miss_nx;
   logic [1:0]              best;
   logic [CW-1:0]           unused_match;
   logic                    hit, accept, pay_last, sof_last;
   logic                    lock_hit, take_pay, chk_acc, chk_hit, chk_miss;

   // a single output register: accept whenever it is empty or draining
   assign in_ready = ~out_valid | out_ready;
   assign accept   = in_valid & in_ready;
   assign locked   = (state != SEARCH);
   assign pay_last = (pay_cnt == PW'(FRAME_LEN-1));
   assign sof_last = (sof_cnt == SW'(SOF_LEN-1));
   assign miss_nx  = miss_cnt + MW'(1);

   // newest symbol joins the window in the same cycle it is accepted
   assign window = {hist, in_data};

   sof_correlator #(.SOF_LEN(SOF_LEN), .MAX_ERR(MAX_ERR)) u_corr (
      .window     (window),
      .pattern    (SOF_PATTERN),
      .best       (best),
      .match_best (unused_match),
      .hit        (hit)
   );

   // state register
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state <= SEARCH;
      else        state <= state_nx;

   // next-state logic
   always_comb begin
      state_nx = state;
      case (state)
         SEARCH:  if (lock_hit) state_nx = PAYLOAD;
         PAYLOAD: if (take_pay && pay_last) state_nx = CHECK;
         CHECK: begin
            if (chk_hit)       state_nx = PAYLOAD;
            else if (chk_miss) state_nx = (miss_nx == MW'(MISS_LIMIT)) ? SEARCH : PAYLOAD;
         end
         default: state_nx = SEARCH;
      endcase
   end

   // per-state decode of what an accepted symbol means
   always_comb begin
      lock_hit = 1'b0;
      take_pay = 1'b0;
      chk_acc  = 1'b0;
      chk_hit  = 1'b0;
      chk_miss = 1'b0;
      case (state)
         SEARCH:  lock_hit = accept & hit;
         PAYLOAD: take_pay = accept;
         CHECK: begin
            chk_acc  = accept;
            chk_hit  = accept & sof_last & hit;
            chk_miss = accept & sof_last & ~hit;
         end
         default: ;
      endcase
   end

   // history, counters, rotation latch and the output register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hist      <= '0;
         pay_cnt   <= '0;
         sof_cnt   <= '0;
         miss_cnt  <= '0;
         rot       <= 2'd0;
         sof_miss  <= 1'b0;
         out_valid <= 1'b0;
         out_data  <= 2'd0;
         out_sof   <= 1'b0;
         out_eof   <= 1'b0;
      end else begin
         if (accept) hist <= window[SOF_LEN-2:0];

         // a miss keeps the old rotation, even when dropping back to search
         if (lock_hit || chk_hit) rot <= best;

         if (lock_hit || chk_hit) miss_cnt <= '0;
         else if (chk_miss)       miss_cnt <= miss_nx;

         if (lock_hit || chk_hit || chk_miss) pay_cnt <= '0;
         else if (take_pay)                   pay_cnt <= pay_last ? '0 : pay_cnt + PW'(1);

         if (take_pay && pay_last) sof_cnt <= '0;
         else if (chk_acc)         sof_cnt <= sof_last ? '0 : sof_cnt + SW'(1);

         sof_miss <= chk_miss;

         if (take_pay) begin
            out_valid <= 1'b1;
            out_data  <= derot(in_data, rot);
            out_sof   <= (pay_cnt == '0);
            out_eof   <= pay_last;
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_qpsk_frame_sync.sv
// Scoreboard bench for qpsk_frame_sync: symbol streams are built per test,
// a frame-level reference model turns each stream into expected outputs,
// and a monitor checks every handshake against that queue.
`timescale 1ns/1ps
module tb_qpsk_frame_sync;
   localparam int          SL  = 26;
   localparam int          FL  = 63;
   localparam int          ME  = 3;
   localparam int          ML  = 3;
   localparam logic [25:0] PAT = 26'h3278428;

   logic       clk = 1'b0, rst_n = 1'b1;
   logic       in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b1;
   logic [1:0] in_data = 2'd0, out_data, rot;
   logic       out_sof, out_eof, locked, sof_miss;

   always #5 clk = ~clk;

   qpsk_frame_sync dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
      .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_sof(out_sof), .out_eof(out_eof),
      .locked(locked), .rot(rot), .sof_miss(sof_miss)
   );

   typedef struct packed {logic [1:0] d; logic s; logic e;} exp_t;

   exp_t       exp_q[$];
   logic [1:0] str[$];
   logic [25:0] pat = PAT;
   int         checks = 0, errors = 0, miss_seen = 0, n_out = 0;
   bit         rnd_ready = 0;
   int         ph_of[4]  = '{0, 3, 1, 2};                 // indexed by symbol value
   logic [1:0] sym_of[4] = '{2'b00, 2'b10, 2'b11, 2'b01}; // indexed by phase

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", nm, act, expv);
      end
   endtask

   function automatic logic [1:0] rotsym(input logic [1:0] s, input int r);
      return sym_of[(ph_of[s] + r) % 4];
   endfunction

   // ---------------- stream construction ----------------
   task automatic add_sof(input int r, input int nerr);
      logic [1:0] blk[SL];
      bit         bad[SL];
      int         p, c;
      for (int k = 0; k < SL; k++) begin
         blk[k] = rotsym(pat[SL-1-k] ? 2'b11 : 2'b00, r);
         bad[k] = 1'b0;
      end
      c = 0;
      while (c < nerr) begin
         p = $urandom_range(SL-1);
         if (!bad[p]) begin bad[p] = 1'b1; blk[p] = rotsym(blk[p], 2); c++; end
      end
      for (int k = 0; k < SL; k++) str.push_back(blk[k]);
   endtask

   task automatic add_pay(input int n, input int r, input bit cyc);
      logic [1:0] s;
      for (int k = 0; k < n; k++) begin
         s = cyc ? 2'(k % 4) : 2'($urandom % 4);
         str.push_back(rotsym(s, r));
      end
   endtask

   // ---------------- reference model ----------------
   // score the SL symbols ending at stream index endi (before the stream: zeros)
   task automatic corr(input int endi, output int bestr, output int bestm);
      int         m, j;
      logic [1:0] s;
      bestr = 0; bestm = -1;
      for (int r = 0; r < 4; r++) begin
         m = 0;
         for (int k = 0; k < SL; k++) begin
            j = endi - SL + 1 + k;
            s = (j < 0) ? 2'b00 : str[j];
            if (((ph_of[s] - r + 4) % 4) == (pat[SL-1-k] ? 2 : 0)) m++;
         end
         if (m > bestm) begin bestm = m; bestr = r; end
      end
   endtask

   task automatic emit_frame(inout int i, input int r);
      exp_t e;
      for (int k = 0; k < FL && i < str.size(); k++) begin
         e.d = sym_of[(ph_of[str[i]] - r + 4) % 4];
         e.s = (k == 0);
         e.e = (k == FL-1);
         exp_q.push_back(e);
         i++;
      end
   endtask

   // walk the stream a frame at a time: search, then frame + SOF block pairs
   task automatic run_model(output int misses, output bit lk, output int rt);
      int i, br, bm, mc, n;
      bit srch;
      n = str.size(); i = 0; mc = 0; misses = 0; rt = 0; srch = 1;
      while (i < n) begin
         if (srch) begin
            corr(i, br, bm);
            i++;
            if (bm >= SL - ME) begin rt = br; mc = 0; srch = 0; emit_frame(i, rt); end
         end else begin
            if (i + SL > n) break;
            corr(i + SL - 1, br, bm);
            i += SL;
            if (bm >= SL - ME) begin rt = br; mc = 0; end
            else begin misses++; mc++; end
            if (mc == ML) srch = 1;
            else          emit_frame(i, rt);
         end
      end
      lk = !srch;
   endtask

   // ---------------- drivers ----------------
   task automatic send(input logic [1:0] s, input bit gaps);
      int t;
      bit done;
      if (gaps && ($urandom % 4 == 0)) begin
         in_valid = 1'b0;
         @(posedge clk); #1;
      end
      in_valid = 1'b1; in_data = s;
      done = 0; t = 0;
      while (!done) begin
         @(negedge clk);
         done = in_ready;
         @(posedge clk); #1;
         if (++t > 200) begin
            errors++; checks++;
            $display("FAIL in_ready timeout: got 0 expected 1");
            done = 1;
         end
      end
   endtask

   task automatic drive_range(input int lo, input int hi, input bit gaps);
      for (int i = lo; i < hi; i++) send(str[i], gaps);
      in_valid = 1'b0;
   endtask

   task automatic wait_drain();
      int t = 0;
      while ((exp_q.size() != 0 || out_valid) && t < 2000) begin @(posedge clk); t++; end
      repeat (3) @(posedge clk);
      #1;
      chk("drain pending outputs", exp_q.size(), 0);
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset out_valid", out_valid, 0);
      chk("reset out_data", out_data, 0);
      chk("reset sof/eof", {out_sof, out_eof}, 0);
      chk("reset locked", locked, 0);
      chk("reset rot", rot, 0);
      chk("reset sof_miss", sof_miss, 0);
      @(negedge clk);
      rst_n = 1'b1;
      exp_q.delete(); str.delete();
      miss_seen = 0;
      @(posedge clk); #1;
   endtask

   task automatic end_checks(input string nm, input int ms, input bit lk, input int rt);
      chk({nm, " locked"}, locked, lk);
      chk({nm, " rot"}, rot, rt);
      chk({nm, " sof_miss pulses"}, miss_seen, ms);
   endtask

   // ready pattern for the downstream side
   initial forever begin
      @(posedge clk); #1;
      out_ready = rnd_ready ? 1'($urandom % 2) : 1'b1;
   end

   // ---------------- monitor ----------------
   bit         prev_stall = 0;
   logic [3:0] prev_o;
   initial forever begin
      exp_t e;
      @(negedge clk);
      if (!rst_n) prev_stall = 0;
      else begin
         if (prev_stall) begin
            checks++;
            if (!(out_valid && {out_data, out_sof, out_eof} == prev_o)) begin
               errors++;
               $display("FAIL stall hold: got v=%0b o=%h expected v=1 o=%h", out_valid,
                        {out_data, out_sof, out_eof}, prev_o);
            end
         end
         if (sof_miss) miss_seen++;
         if (out_valid && out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected output: got d=%0d sof=%0b eof=%0b expected none",
                        out_data, out_sof, out_eof);
            end else begin
               e = exp_q.pop_front();
               if ({out_data, out_sof, out_eof} !== {e.d, e.s, e.e}) begin
                  errors++;
                  $display("FAIL output %0d: got d=%0d sof=%0b eof=%0b expected d=%0d sof=%0b eof=%0b",
                           n_out, out_data, out_sof, out_eof, e.d, e.s, e.e);
               end
            end
            n_out++;
         end
         prev_stall = out_valid && !out_ready;
         prev_o     = {out_data, out_sof, out_eof};
      end
   end

   // ---------------- tests ----------------
   initial begin
      int ms, rt, cut, r;
      bit lk;

      // clean SOF at rotation 0, cycling payload
      do_reset();
      add_sof(0, 0); add_pay(FL, 0, 1);
      run_model(ms, lk, rt);
      drive_range(0, str.size(), 0);
      wait_drain();
      end_checks("t1", ms, lk, rt);
      chk("t1 locked const", locked, 1);

      // whole stream rotated 180 degrees, 3 SOF errors
      do_reset();
      add_pay(10, 2, 0); add_sof(2, 3); add_pay(FL, 2, 0);
      run_model(ms, lk, rt);
      drive_range(0, str.size(), 0);
      wait_drain();
      end_checks("t2", ms, lk, rt);
      chk("t2 rot const", rot, 2);

      // one bad SOF is flywheeled through, with input gaps
      do_reset();
      add_sof(1, 0); add_pay(FL, 1, 0);
      add_sof(1, 5); add_pay(FL, 1, 0);
      add_sof(1, 0); add_pay(FL, 1, 0);
      run_model(ms, lk, rt);
      drive_range(0, str.size(), 1);
      wait_drain();
      end_checks("t3", ms, lk, rt);
      chk("t3 one miss const", miss_seen, 1);

      // three bad SOFs in a row drop lock, then a clean SOF re-acquires
      do_reset();
      add_sof(3, 0); add_pay(FL, 3, 0);
      add_sof(3, 5); add_pay(FL, 3, 0);
      add_sof(3, 4); add_pay(FL, 3, 0);
      add_sof(3, 5);
      cut = str.size();
      add_pay(FL, 3, 0);
      add_sof(0, 1); add_pay(FL, 0, 0);
      run_model(ms, lk, rt);
      drive_range(0, cut, 0);
      repeat (4) @(posedge clk);
      #1;
      chk("t4 unlocked after 3 misses", locked, 0);
      chk("t4 miss pulses at drop", miss_seen, 3);
      drive_range(cut, str.size(), 0);
      wait_drain();
      end_checks("t4", ms, lk, rt);

      // random downstream backpressure, two frames
      do_reset();
      rnd_ready = 1;
      add_sof(1, 2); add_pay(FL, 1, 0);
      add_sof(1, 0); add_pay(FL, 1, 0);
      add_sof(1, 0);
      run_model(ms, lk, rt);
      drive_range(0, str.size(), 0);
      wait_drain();
      rnd_ready = 0;
      end_checks("t5", ms, lk, rt);

      // random rotations and error counts within tolerance
      for (int it = 0; it < 2; it++) begin
         do_reset();
         r = $urandom % 4;
         add_pay(5, r, 0); add_sof(r, $urandom_range(ME)); add_pay(FL, r, 0); add_sof(r, 0);
         run_model(ms, lk, rt);
         drive_range(0, str.size(), 1);
         wait_drain();
         end_checks("t7", ms, lk, rt);
      end

      // asynchronous reset in the middle of a frame, then re-acquisition
      do_reset();
      add_sof(0, 0); add_pay(30, 0, 0);
      run_model(ms, lk, rt);
      void'(exp_q.pop_back());   // presented when reset hits, never consumed
      drive_range(0, str.size(), 0);
      chk("t6 output live before reset", out_valid, 1);
      #1 rst_n = 1'b0;
      #1;
      chk("t6 async out_valid", out_valid, 0);
      chk("t6 async out_data", out_data, 0);
      chk("t6 async locked", locked, 0);
      chk("t6 no partial frame left", exp_q.size(), 0);
      @(negedge clk);
      rst_n = 1'b1;
      str.delete(); miss_seen = 0;
      add_pay(12, 0, 0); add_sof(2, 0); add_pay(FL, 2, 0);
      run_model(ms, lk, rt);
      drive_range(0, str.size(), 0);
      wait_drain();
      end_checks("t6", ms, lk, rt);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #800000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

endmodule
